// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, owner and op encodings.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF      = 25;
  localparam int DATA_W_DEF      = 8;
  localparam int HOST_STARVE_DEF = 8;
  localparam int RD_TIMEOUT_DEF  = 63;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GUARD   = 2'd1,
    RD_WAIT = 2'd2,
    WR_WAIT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SPI  = 2'd1,
    HOST = 2'd2
  } owner_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_e;

  // Width of a counter that must hold 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundles the two requester ports and the controller port of the SDRAM arbiter.
// Latency: n/a (wiring only).
// Backpressure: req/ack handshakes, controller busy; see sdram_arbiter.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8
);

  // SPI flash-emulation read port
  logic              spi_req;
  logic [ADDR_W-1:0] spi_addr;
  logic              spi_ack;
  logic [DATA_W-1:0] spi_rdata;
  logic              spi_rvalid;

  // Host / UART command port
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic              rd_timeout;

  // SDRAM controller logical port
  logic [ADDR_W-1:0] sd_rd_addr;
  logic              sd_rd_enable;
  logic [ADDR_W-1:0] sd_wr_addr;
  logic [DATA_W-1:0] sd_wr_data;
  logic              sd_wr_enable;
  logic [DATA_W-1:0] sd_rd_data;
  logic              sd_rd_ready;
  logic              sd_busy;

  // Arbiter side
  modport slave (
    input  spi_req, spi_addr,
    input  host_req, host_we, host_addr, host_wdata,
    input  sd_rd_data, sd_rd_ready, sd_busy,
    output spi_ack, spi_rdata, spi_rvalid,
    output host_ack, host_rdata, host_rvalid,
    output rd_timeout,
    output sd_rd_addr, sd_rd_enable, sd_wr_addr, sd_wr_data, sd_wr_enable
  );

  // Requesters plus controller side
  modport master (
    output spi_req, spi_addr,
    output host_req, host_we, host_addr, host_wdata,
    output sd_rd_data, sd_rd_ready, sd_busy,
    input  spi_ack, spi_rdata, spi_rvalid,
    input  host_ack, host_rdata, host_rvalid,
    input  rd_timeout,
    input  sd_rd_addr, sd_rd_enable, sd_wr_addr, sd_wr_data, sd_wr_enable
  );

endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between a high-priority SPI read path and a host path.
// Latency: grant registered 1 cycle after req seen in IDLE; read data 1 cycle after sd_rd_ready.
// Backpressure: one access in flight; requesters hold req until ack; waits on sd_busy.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HOST_STARVE = HOST_STARVE_DEF,
  parameter int RD_TIMEOUT  = RD_TIMEOUT_DEF
) (
  input logic             clk,
  input logic             rst_n,
  sdram_arbiter_if.slave  bus
);

  localparam int SW = cnt_w(HOST_STARVE);
  localparam int TW = cnt_w(RD_TIMEOUT);

  localparam logic [SW-1:0] STARVE_MAX = SW'(HOST_STARVE);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(RD_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);

  // Control state
  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  op_e           op_q, op_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Registered outputs
  logic [ADDR_W-1:0] sd_rd_addr_q, sd_rd_addr_d;
  logic              sd_rd_enable_q, sd_rd_enable_d;
  logic [ADDR_W-1:0] sd_wr_addr_q, sd_wr_addr_d;
  logic [DATA_W-1:0] sd_wr_data_q, sd_wr_data_d;
  logic              sd_wr_enable_q, sd_wr_enable_d;
  logic              spi_ack_q, spi_ack_d;
  logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
  logic              spi_rvalid_q, spi_rvalid_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              rd_timeout_q, rd_timeout_d;

  logic spi_grant;
  logic host_grant;

  // Pick this cycle's winner; SPI by default, host once the SPI streak has hit the limit.
  always_comb begin
    spi_grant  = 1'b0;
    host_grant = 1'b0;
    if (state_q == IDLE && !bus.sd_busy) begin
      if (bus.host_req && (!bus.spi_req || starve_cnt_q == STARVE_MAX)) begin
        host_grant = 1'b1;
      end else if (bus.spi_req) begin
        spi_grant = 1'b1;
      end
    end
  end

  // Count SPI grants that bypassed a waiting host; forget the streak once host is idle or served.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.host_req || host_grant) begin
      starve_cnt_d = '0;
    end else if (spi_grant && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + STARVE_ONE;
    end
  end

  // FSM next-state plus next values of every registered output; pulses default low.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    op_d           = op_q;
    tmo_cnt_d      = tmo_cnt_q;
    sd_rd_addr_d   = sd_rd_addr_q;
    sd_wr_addr_d   = sd_wr_addr_q;
    sd_wr_data_d   = sd_wr_data_q;
    spi_rdata_d    = spi_rdata_q;
    host_rdata_d   = host_rdata_q;
    sd_rd_enable_d = 1'b0;
    sd_wr_enable_d = 1'b0;
    spi_ack_d      = 1'b0;
    spi_rvalid_d   = 1'b0;
    host_ack_d     = 1'b0;
    host_rvalid_d  = 1'b0;
    rd_timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (host_grant) begin
          owner_d    = HOST;
          host_ack_d = 1'b1;
          state_d    = GUARD;
          if (bus.host_we) begin
            op_d           = WR;
            sd_wr_addr_d   = bus.host_addr;
            sd_wr_data_d   = bus.host_wdata;
            sd_wr_enable_d = 1'b1;
          end else begin
            op_d           = RD;
            sd_rd_addr_d   = bus.host_addr;
            sd_rd_enable_d = 1'b1;
          end
        end else if (spi_grant) begin
          owner_d        = SPI;
          op_d           = RD;
          spi_ack_d      = 1'b1;
          sd_rd_addr_d   = bus.spi_addr;
          sd_rd_enable_d = 1'b1;
          state_d        = GUARD;
        end
      end

      // The controller's busy is registered, so it cannot reflect our enable yet.
      GUARD: begin
        tmo_cnt_d = '0;
        state_d   = (op_q == RD) ? RD_WAIT : WR_WAIT;
      end

      RD_WAIT: begin
        if (bus.sd_rd_ready) begin
          if (owner_q == SPI) begin
            spi_rdata_d  = bus.sd_rd_data;
            spi_rvalid_d = 1'b1;
          end else if (owner_q == HOST) begin
            host_rdata_d  = bus.sd_rd_data;
            host_rvalid_d = 1'b1;
          end
          owner_d = NONE;
          state_d = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Give up on the read so neither requester can wedge the port.
          rd_timeout_d = 1'b1;
          owner_d      = NONE;
          state_d      = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
      end

      WR_WAIT: begin
        if (!bus.sd_busy) begin
          owner_d = NONE;
          state_d = IDLE;
        end
      end

      default: begin
        owner_d = NONE;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= NONE;
      op_q           <= RD;
      starve_cnt_q   <= '0;
      tmo_cnt_q      <= '0;
      sd_rd_addr_q   <= '0;
      sd_rd_enable_q <= 1'b0;
      sd_wr_addr_q   <= '0;
      sd_wr_data_q   <= '0;
      sd_wr_enable_q <= 1'b0;
      spi_ack_q      <= 1'b0;
      spi_rdata_q    <= '0;
      spi_rvalid_q   <= 1'b0;
      host_ack_q     <= 1'b0;
      host_rdata_q   <= '0;
      host_rvalid_q  <= 1'b0;
      rd_timeout_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      op_q           <= op_d;
      starve_cnt_q   <= starve_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      sd_rd_addr_q   <= sd_rd_addr_d;
      sd_rd_enable_q <= sd_rd_enable_d;
      sd_wr_addr_q   <= sd_wr_addr_d;
      sd_wr_data_q   <= sd_wr_data_d;
      sd_wr_enable_q <= sd_wr_enable_d;
      spi_ack_q      <= spi_ack_d;
      spi_rdata_q    <= spi_rdata_d;
      spi_rvalid_q   <= spi_rvalid_d;
      host_ack_q     <= host_ack_d;
      host_rdata_q   <= host_rdata_d;
      host_rvalid_q  <= host_rvalid_d;
      rd_timeout_q   <= rd_timeout_d;
    end
  end

  assign bus.sd_rd_addr   = sd_rd_addr_q;
  assign bus.sd_rd_enable = sd_rd_enable_q;
  assign bus.sd_wr_addr   = sd_wr_addr_q;
  assign bus.sd_wr_data   = sd_wr_data_q;
  assign bus.sd_wr_enable = sd_wr_enable_q;
  assign bus.spi_ack      = spi_ack_q;
  assign bus.spi_rdata    = spi_rdata_q;
  assign bus.spi_rvalid   = spi_rvalid_q;
  assign bus.host_ack     = host_ack_q;
  assign bus.host_rdata   = host_rdata_q;
  assign bus.host_rvalid  = host_rvalid_q;
  assign bus.rd_timeout   = rd_timeout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a small behavioural SDRAM controller.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int AW = 25;
  localparam int DW = 8;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .HOST_STARVE(8), .RD_TIMEOUT(63)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- controller model ----------------
  int          rd_lat      = 6;
  bit          rd_respond  = 1'b1;
  bit          inject_rdy  = 1'b0;
  logic [7:0]  inject_data = 8'h00;
  logic [7:0]  mem [logic [24:0]];
  int          rcnt = 0;
  int          wcnt = 0;
  logic [24:0] raddr;

  function automatic logic [7:0] rd_model(input logic [24:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  initial begin
    bus.sd_busy     = 1'b0;
    bus.sd_rd_ready = 1'b0;
    bus.sd_rd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.sd_rd_ready = 1'b0;
      if (inject_rdy) begin
        bus.sd_rd_ready = 1'b1;
        bus.sd_rd_data  = inject_data;
        inject_rdy      = 1'b0;
      end else if (bus.sd_rd_enable) begin
        bus.sd_busy = 1'b1;
        rcnt        = rd_lat;
        raddr       = bus.sd_rd_addr;
      end else if (bus.sd_wr_enable) begin
        bus.sd_busy = 1'b1;
        wcnt        = 2;
        mem[bus.sd_wr_addr] = bus.sd_wr_data;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          bus.sd_busy = 1'b0;
          if (rd_respond) begin
            bus.sd_rd_ready = 1'b1;
            bus.sd_rd_data  = rd_model(raddr);
          end
        end
      end else if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) bus.sd_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] spi_q[$];
  logic [7:0] host_q[$];
  bit         grant_log[$];   // 0 = SPI ack, 1 = host ack
  int cyc = 0;
  int spi_rv_cnt = 0, host_rv_cnt = 0, to_cnt = 0;
  int en_rd_cyc = 0, en_wr_cyc = 0, to_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (bus.spi_ack)      grant_log.push_back(1'b0);
        if (bus.host_ack)     grant_log.push_back(1'b1);
        if (bus.sd_rd_enable) en_rd_cyc = cyc;
        if (bus.sd_wr_enable) en_wr_cyc = cyc;
        if (bus.rd_timeout) begin
          to_cnt++;
          to_cyc = cyc;
        end
        if (bus.spi_rvalid) begin
          spi_rv_cnt++;
          if (spi_q.size() == 0) chk("spi_rvalid_unexpected", 1, 0);
          else                   chk("spi_rdata", bus.spi_rdata, spi_q.pop_front());
        end
        if (bus.host_rvalid) begin
          host_rv_cnt++;
          if (host_q.size() == 0) chk("host_rvalid_unexpected", 1, 0);
          else                    chk("host_rdata", bus.host_rdata, host_q.pop_front());
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  // Called at a negedge; returns one negedge after the ack was seen.
  task automatic do_req(input bit host, input bit we, input logic [24:0] a,
                        input logic [7:0] wd, input bit expect_rd, input bit keep);
    bit    got;
    string p;
    p = host ? "host_" : "spi_";
    if (!we && expect_rd) begin
      if (host) host_q.push_back(rd_model(a));
      else      spi_q.push_back(rd_model(a));
    end
    if (host) begin
      bus.host_req   = 1'b1;
      bus.host_we    = we;
      bus.host_addr  = a;
      bus.host_wdata = wd;
    end else begin
      bus.spi_req  = 1'b1;
      bus.spi_addr = a;
    end
    got = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (host ? bus.host_ack : bus.spi_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk({p, "ack_seen"}, 32'(got), 1);
    if (got) begin
      if (we) begin
        chk({p, "wr_enable"}, 32'(bus.sd_wr_enable), 1);
        chk({p, "wr_addr"}, 32'(bus.sd_wr_addr), 32'(a));
        chk({p, "wr_data"}, 32'(bus.sd_wr_data), 32'(wd));
      end else begin
        chk({p, "rd_enable"}, 32'(bus.sd_rd_enable), 1);
        chk({p, "rd_addr"}, 32'(bus.sd_rd_addr), 32'(a));
      end
    end
    if (!keep) begin
      if (host) bus.host_req = 1'b0;
      else      bus.spi_req  = 1'b0;
    end
    @(negedge clk);
    if (got) begin
      chk({p, "ack_pulse"}, 32'(host ? bus.host_ack : bus.spi_ack), 0);
      chk({p, "enable_pulse"}, 32'({bus.sd_rd_enable, bus.sd_wr_enable}), 0);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (spi_q.size() != 0 || host_q.size() != 0); n++)
      @(negedge clk);
    chk("drain_spi", spi_q.size(), 0);
    chk("drain_host", host_q.size(), 0);
  endtask

  function automatic logic any_out();
    return |{bus.spi_ack, bus.spi_rdata, bus.spi_rvalid, bus.host_ack, bus.host_rdata,
             bus.host_rvalid, bus.rd_timeout, bus.sd_rd_addr, bus.sd_rd_enable,
             bus.sd_wr_addr, bus.sd_wr_data, bus.sd_wr_enable};
  endfunction

  // Expected grant order for the starvation run: 8 SPI, host, 3 SPI.
  bit exp_order[$];

  initial begin
    int s0, h0, t0;
    rst_n          = 1'b0;
    bus.spi_req    = 1'b0;
    bus.spi_addr   = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", 32'(any_out()), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs_zero", 32'(any_out()), 0);

    // Single SPI read
    s0 = spi_rv_cnt; h0 = host_rv_cnt;
    do_req(1'b0, 1'b0, 25'h000100, 8'h00, 1'b1, 1'b0);
    drain();
    chk("t1_spi_rvalid_count", spi_rv_cnt - s0, 1);
    chk("t1_host_rvalid_count", host_rv_cnt - h0, 0);

    // Host write then an SPI read waiting behind it
    do_req(1'b1, 1'b1, 25'h1FFFFFF, 8'h3C, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 25'h000155, 8'h00, 1'b1, 1'b0);
    chk("wr_to_next_grant_cycles", en_rd_cyc - en_wr_cyc, 4);
    drain();

    // Simultaneous requests, starve_cnt at 0
    grant_log.delete();
    s0 = spi_rv_cnt; h0 = host_rv_cnt;
    fork
      do_req(1'b0, 1'b0, 25'h000312, 8'h00, 1'b1, 1'b0);
      do_req(1'b1, 1'b0, 25'h0004C7, 8'h00, 1'b1, 1'b0);
    join
    drain();
    chk("simul_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("simul_first_spi", 32'(grant_log[0]), 0);
      chk("simul_second_host", 32'(grant_log[1]), 1);
    end
    chk("simul_spi_rvalid", spi_rv_cnt - s0, 1);
    chk("simul_host_rvalid", host_rv_cnt - h0, 1);

    // Starvation guard: SPI held continuously, host read pending
    grant_log.delete();
    exp_order.delete();
    for (int i = 0; i < 8; i++) exp_order.push_back(1'b0);
    exp_order.push_back(1'b1);
    for (int i = 0; i < 3; i++) exp_order.push_back(1'b0);
    fork
      begin
        for (int i = 0; i < 11; i++)
          do_req(1'b0, 1'b0, 25'h010000 + 25'(i * 7), 8'h00, 1'b1, i < 10);
      end
      do_req(1'b1, 1'b0, 25'h002222, 8'h00, 1'b1, 1'b0);
    join
    drain();
    chk("starve_grant_count", grant_log.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
      chk($sformatf("starve_order_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));

    // Read timeout
    rd_respond = 1'b0;
    s0 = spi_rv_cnt; t0 = to_cnt;
    do_req(1'b0, 1'b0, 25'h000777, 8'h00, 1'b0, 1'b0);
    for (int n = 0; n < 200 && to_cnt == t0; n++) @(negedge clk);
    chk("timeout_seen", to_cnt - t0, 1);
    chk("timeout_delay", to_cyc - en_rd_cyc, 64);
    repeat (3) @(negedge clk);
    chk("timeout_single_pulse", to_cnt - t0, 1);
    chk("timeout_no_rvalid", spi_rv_cnt - s0, 0);
    rd_respond = 1'b1;
    h0 = host_rv_cnt;
    do_req(1'b1, 1'b0, 25'h000888, 8'h00, 1'b1, 1'b0);
    drain();
    chk("after_timeout_host_rvalid", host_rv_cnt - h0, 1);

    // Reset while in RD_WAIT, then a stale rd_ready
    rd_respond = 1'b0;
    s0 = spi_rv_cnt; h0 = host_rv_cnt;
    do_req(1'b0, 1'b0, 25'h000999, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs_zero", 32'(any_out()), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    inject_data = 8'h77;
    inject_rdy  = 1'b1;
    repeat (10) @(negedge clk);
    chk("late_ready_no_spi_rvalid", spi_rv_cnt - s0, 0);
    chk("late_ready_no_host_rvalid", host_rv_cnt - h0, 0);
    chk("late_ready_outputs_zero", 32'(any_out()), 0);
    rd_respond = 1'b1;
    do_req(1'b0, 1'b0, 25'h000AB1, 8'h00, 1'b1, 1'b0);
    drain();
    chk("after_reset_spi_rvalid", spi_rv_cnt - s0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
